// File: rtl/vga_pkg.sv
// Shared 720p timing constants, controller state encoding and sync bundle type.
package vga_pkg;

    localparam int IMAGE_WIDTH_DEF   = 1280;
    localparam int HFP_WIDTH_DEF     = 110;
    localparam int HSYNCH_WIDTH_DEF  = 40;
    localparam int HBP_WIDTH_DEF     = 220;
    localparam int IMAGE_HEIGHT_DEF  = 720;
    localparam int VFP_HEIGHT_DEF    = 5;
    localparam int VSYNCH_HEIGHT_DEF = 5;
    localparam int VBP_HEIGHT_DEF    = 20;
    localparam int PIPE_DELAY_DEF    = 1;

    localparam int H_TOTAL = IMAGE_WIDTH_DEF + HFP_WIDTH_DEF + HSYNCH_WIDTH_DEF + HBP_WIDTH_DEF;
    localparam int V_TOTAL = IMAGE_HEIGHT_DEF + VFP_HEIGHT_DEF + VSYNCH_HEIGHT_DEF + VBP_HEIGHT_DEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } vga_state_t;

    // Bits that travel down the delay line alongside the ROM read.
    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
    } sync_bits_t;

endpackage

// File: rtl/vga_timing_ctrl_sync_delay.sv
// Fixed-depth delay line for {valid, hs, vs}; DEPTH=0 is a plain wire.
module sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  sync_bits_t din,
    output sync_bits_t dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, reset_n};
            assign dout = din;
        end else begin : g_pipe
            sync_bits_t vld_pipe [DEPTH];

            // Shift every clock regardless of controller state so IDLE drains zeros.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) vld_pipe[i] <= '0;
                end else begin
                    vld_pipe[0] <= din;
                    for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            assign dout = vld_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster position counters, run/stop sequencing and delayed sync generation.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int IMAGE_WIDTH   = IMAGE_WIDTH_DEF,
    parameter int HFP_WIDTH     = HFP_WIDTH_DEF,
    parameter int HSYNCH_WIDTH  = HSYNCH_WIDTH_DEF,
    parameter int HBP_WIDTH     = HBP_WIDTH_DEF,
    parameter int IMAGE_HEIGHT  = IMAGE_HEIGHT_DEF,
    parameter int VFP_HEIGHT    = VFP_HEIGHT_DEF,
    parameter int VSYNCH_HEIGHT = VSYNCH_HEIGHT_DEF,
    parameter int VBP_HEIGHT    = VBP_HEIGHT_DEF,
    parameter int PIPE_DELAY    = PIPE_DELAY_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [31:0] H_pos,
    output logic [31:0] V_pos,
    output logic        valid_video,
    output logic        valid_video_d,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_count,
    output logic        running
);

    localparam logic [31:0] H_LAST   = 32'(IMAGE_WIDTH + HFP_WIDTH + HSYNCH_WIDTH + HBP_WIDTH - 1);
    localparam logic [31:0] V_LAST   = 32'(IMAGE_HEIGHT + VFP_HEIGHT + VSYNCH_HEIGHT + VBP_HEIGHT - 1);
    localparam logic [31:0] H_ACT    = 32'(IMAGE_WIDTH);
    localparam logic [31:0] V_ACT    = 32'(IMAGE_HEIGHT);
    localparam logic [31:0] HS_BEGIN = 32'(IMAGE_WIDTH + HFP_WIDTH);
    localparam logic [31:0] HS_END   = 32'(IMAGE_WIDTH + HFP_WIDTH + HSYNCH_WIDTH);
    localparam logic [31:0] VS_BEGIN = 32'(IMAGE_HEIGHT + VFP_HEIGHT);
    localparam logic [31:0] VS_END   = 32'(IMAGE_HEIGHT + VFP_HEIGHT + VSYNCH_HEIGHT);

    vga_state_t  state, state_nxt;
    logic [31:0] h_cnt, h_nxt;
    logic [31:0] v_cnt, v_nxt;
    logic [15:0] fc_q, fc_nxt;
    logic        h_last, v_last, active;
    sync_bits_t  sync_raw, sync_d;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign active = (state != IDLE);

    // State, position and frame counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            fc_q  <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            fc_q  <= fc_nxt;
        end
    end

    // Next state and counter advance; STOPPING only retires after the frame's last pixel.
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        fc_nxt    = fc_q;
        case (state)
            IDLE:     if (enable) state_nxt = RUN;
            RUN:      if (!enable) state_nxt = STOPPING;
            STOPPING: begin
                if (enable)               state_nxt = RUN;
                else if (h_last && v_last) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
        if (!active) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (h_last) begin
            h_nxt = '0;
            if (v_last) begin
                v_nxt  = '0;
                fc_nxt = fc_q + 16'd1;
            end else begin
                v_nxt = v_cnt + 32'd1;
            end
        end else begin
            h_nxt = h_cnt + 32'd1;
        end
    end

    // Region decode straight off the registers so it lines up with the position.
    always_comb begin
        sync_raw.valid = active && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        sync_raw.hs    = active && (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        sync_raw.vs    = active && (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
    end

    sync_delay #(.DEPTH(PIPE_DELAY)) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync_raw),
        .dout    (sync_d)
    );

    assign H_pos         = h_cnt;
    assign V_pos         = v_cnt;
    assign valid_video   = sync_raw.valid;
    assign valid_video_d = sync_d.valid;
    assign VGA_HS        = sync_d.hs;
    assign VGA_VS        = sync_d.vs;
    assign frame_start   = active && (h_cnt == '0) && (v_cnt == '0);
    assign line_start    = active && (h_cnt == '0);
    assign frame_count   = fc_q;
    assign running       = active;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboarded directed test of vga_timing_ctrl on a shrunken 16x8 raster.
module tb_vga_timing_ctrl;

    localparam int IW = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int IH = 4, VFP = 1, VSW = 2, VBP = 1;
    localparam int PD = 2;
    localparam int HT = IW + HFP + HSW + HBP;   // 16
    localparam int VT = IH + VFP + VSW + VBP;   // 8

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] H_pos, V_pos;
    logic        valid_video, valid_video_d, VGA_HS, VGA_VS;
    logic        frame_start, line_start, running;
    logic [15:0] frame_count;

    vga_timing_ctrl #(
        .IMAGE_WIDTH(IW), .HFP_WIDTH(HFP), .HSYNCH_WIDTH(HSW), .HBP_WIDTH(HBP),
        .IMAGE_HEIGHT(IH), .VFP_HEIGHT(VFP), .VSYNCH_HEIGHT(VSW), .VBP_HEIGHT(VBP),
        .PIPE_DELAY(PD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .H_pos(H_pos), .V_pos(V_pos),
        .valid_video(valid_video), .valid_video_d(valid_video_d),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .frame_start(frame_start), .line_start(line_start),
        .frame_count(frame_count), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] v;
        logic [15:0] fc;
        logic        vv, vvd, hs, vs, fs, ls, run;
    } obs_t;

    obs_t sb[$];
    int   checks = 0, failures = 0, cyc = 0;

    // reference model state
    int          m_state, mh, mv;
    logic [15:0] mfc;
    logic [2:0]  hist [PD+1];

    // observation statistics
    int   vv_cnt, hs_cnt, vs_cnt, fs_cnt, ls_cnt;
    int   hs_first_h, vs_first_v, last_fs_cyc, fs_gap;
    logic hs_prev = 1'b0, vs_prev = 1'b0;

    function automatic obs_t sample();
        return {H_pos, V_pos, frame_count, valid_video, valid_video_d,
                VGA_HS, VGA_VS, frame_start, line_start, running};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; mh = 0; mv = 0; mfc = '0;
        for (int i = 0; i <= PD; i++) hist[i] = '0;
    endtask

    task automatic clear_stats();
        vv_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; ls_cnt = 0;
        hs_first_h = -1; vs_first_v = -1; last_fs_cyc = -1; fs_gap = -1;
    endtask

    // Advance the model by one clock with the enable the DUT will sample; queue the expectation.
    task automatic model_tick(input logic en);
        obs_t       e;
        logic       act, last;
        logic [2:0] u;
        if (m_state == 0) begin
            if (en) m_state = 1;
        end else begin
            last = (mh == HT-1) && (mv == VT-1);
            if (mh == HT-1) begin
                mh = 0;
                if (mv == VT-1) begin mv = 0; mfc = mfc + 16'd1; end
                else mv = mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (m_state == 1) begin
                if (!en) m_state = 2;
            end else begin
                if (en) m_state = 1;
                else if (last) m_state = 0;
            end
        end
        act  = (m_state != 0);
        u[2] = act && (mh < IW) && (mv < IH);
        u[1] = act && (mh >= IW+HFP) && (mh < IW+HFP+HSW);
        u[0] = act && (mv >= IH+VFP) && (mv < IH+VFP+VSW);
        for (int i = PD; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = u;
        e.h   = 32'(mh);
        e.v   = 32'(mv);
        e.fc  = mfc;
        e.vv  = u[2];
        e.vvd = hist[PD][2];
        e.hs  = hist[PD][1];
        e.vs  = hist[PD][0];
        e.fs  = act && (mh == 0) && (mv == 0);
        e.ls  = act && (mh == 0);
        e.run = act;
        sb.push_back(e);
    endtask

    task automatic step();
        obs_t o, e;
        model_tick(enable);
        @(posedge clk); #1;
        cyc++;
        o = sample();
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL sb_empty cyc=%0d", cyc);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL scoreboard cyc=%0d observed=%h expected=%h", cyc, o, e);
            end
        end
        vv_cnt += int'(valid_video);
        hs_cnt += int'(VGA_HS);
        vs_cnt += int'(VGA_VS);
        ls_cnt += int'(line_start);
        if (VGA_HS && !hs_prev && hs_first_h < 0) hs_first_h = int'(H_pos);
        if (VGA_VS && !vs_prev && vs_first_v < 0) vs_first_v = int'(V_pos);
        if (frame_start) begin
            if (last_fs_cyc >= 0) fs_gap = cyc - last_fs_cyc;
            last_fs_cyc = cyc;
            fs_cnt++;
        end
        hs_prev = VGA_HS;
        vs_prev = VGA_VS;
    endtask

    initial begin
        int n;
        model_reset();
        clear_stats();

        // reset held with enable requested: everything stays at zero
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (2) begin
            @(posedge clk); #1; cyc++;
            check("reset_all_zero", 128'(sample()), 128'(0));
        end

        // first sampled enable after release starts a frame at (0,0)
        reset_n = 1'b1;
        step();
        check("start_frame_start", 128'(frame_start), 128'(1));
        check("start_pos", 128'({H_pos, V_pos}), 128'(0));

        // one full line
        repeat (HT-1) step();
        check("line_valid_cnt", 128'(vv_cnt), 128'(IW));
        check("line_hs_cnt", 128'(hs_cnt), 128'(HSW));
        check("line_hs_first_h", 128'(hs_first_h), 128'(IW+HFP+PD));
        check("line_ls_cnt", 128'(ls_cnt), 128'(1));
        step();
        check("line2_line_start", 128'(line_start), 128'(1));
        check("line2_pos", 128'({H_pos, V_pos}), 128'({32'd0, 32'd1}));

        // run through the end of the second frame
        clear_stats();
        repeat (2*HT*VT - HT - 1 + 1) step();
        check("frames_count", 128'(frame_count), 128'(2));
        check("frames_fs_cnt", 128'(fs_cnt), 128'(2));
        check("frames_fs_gap", 128'(fs_gap), 128'(HT*VT));
        check("frames_vs_cnt", 128'(vs_cnt), 128'(2*VSW*HT));
        check("frames_vs_first_v", 128'(vs_first_v), 128'(IH+VFP));

        // graceful stop mid-frame
        repeat (2*HT + 5) step();
        check("stop_at_pos", 128'({H_pos, V_pos}), 128'({32'd5, 32'd2}));
        enable = 1'b0;
        n = 0;
        while (running && n < 300) begin step(); n++; end
        check("stop_cycles", 128'(n), 128'(HT*VT - 2*HT - 5));
        check("stop_running", 128'(running), 128'(0));
        check("stop_pos", 128'({H_pos, V_pos}), 128'(0));
        check("stop_frame_count", 128'(frame_count), 128'(3));
        repeat (PD) step();
        check("stop_drained", 128'({valid_video_d, VGA_HS, VGA_VS}), 128'(0));

        // resume while stopping: no discontinuity, no extra frame start
        enable = 1'b1;
        repeat (HT + 1) step();
        check("resume_v1", 128'(V_pos), 128'(1));
        clear_stats();
        enable = 1'b0;
        repeat (2*HT) step();
        enable = 1'b1;
        repeat (HT) step();
        check("resume_running", 128'(running), 128'(1));
        check("resume_no_fs", 128'(fs_cnt), 128'(0));
        repeat (70) step();
        check("resume_still_running", 128'(running), 128'(1));
        check("resume_fs_cnt", 128'(fs_cnt), 128'(1));
        check("resume_frame_count", 128'(frame_count), 128'(4));

        // asynchronous reset between edges
        repeat (36) step();
        check("areset_pos", 128'({H_pos, V_pos}), 128'({32'd10, 32'd2}));
        #2 reset_n = 1'b0;
        #1;
        check("areset_immediate", 128'(sample()), 128'(0));
        check("areset_frame_count", 128'(frame_count), 128'(0));
        model_reset();
        sb.delete();
        @(posedge clk); #1; cyc++;
        check("areset_held", 128'(sample()), 128'(0));
        reset_n = 1'b1;
        step();
        check("areset_restart_fs", 128'(frame_start), 128'(1));
        check("areset_restart_pos", 128'({H_pos, V_pos}), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencing controller for the 720p VGA path. It owns the horizontal and vertical position counters that drive the pixel generator's `H_pos`, `V_pos` and `valid_video` inputs. It also produces `VGA_HS` and `VGA_VS`, delayed to line up with the registered ROM output, and handles start/stop of the raster on frame boundaries. It sits between the top level (enable, clock, reset) and the pixel generator/ROM datapath.

## Interface
Parameters:
- `IMAGE_WIDTH`, 1280: active pixels per line
- `HFP_WIDTH`, 110: horizontal front porch, in clocks
- `HSYNCH_WIDTH`, 40: HSYNC pulse width
- `HBP_WIDTH`, 220: horizontal back porch
- `IMAGE_HEIGHT`, 720: active lines
- `VFP_HEIGHT`, 5: vertical front porch, in lines
- `VSYNCH_HEIGHT`, 5: VSYNC pulse width
- `VBP_HEIGHT`, 20: vertical back porch
- `PIPE_DELAY`, 1: clocks from position outputs to ROM data valid; range 0..4

Ports:
- `clk` in 1: pixel clock. One clock domain; no other clocks.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level request to run the raster.
- `H_pos` out 32: horizontal position, 0..H_TOTAL-1.
- `V_pos` out 32: vertical position, 0..V_TOTAL-1.
- `valid_video` out 1: active region, aligned with `H_pos`/`V_pos`.
- `valid_video_d` out 1: `valid_video` delayed by PIPE_DELAY.
- `VGA_HS` out 1: active-high HSYNC, delayed by PIPE_DELAY.
- `VGA_VS` out 1: active-high VSYNC, delayed by PIPE_DELAY.
- `frame_start` out 1: one-cycle pulse when position is (0,0) in RUN or STOPPING.
- `line_start` out 1: one-cycle pulse when H_pos=0 in RUN or STOPPING.
- `frame_count` out 16: count of completed frames.
- `running` out 1: high when state is not IDLE.

## Operation
- Derived constants:
  - H_TOTAL = sum of the four horizontal parameters (1650).
  - V_TOTAL = sum of the four vertical parameters (750).
- States: IDLE, RUN, STOPPING.
  - IDLE → RUN when `enable`=1 at a clock edge.
  - RUN → STOPPING when `enable`=0.
  - STOPPING → RUN when `enable`=1. Counters are not disturbed.
  - STOPPING → IDLE on the edge where the last pixel (H_TOTAL-1, V_TOTAL-1) advances.
- Counters in RUN and STOPPING:
  - H increments every clock and wraps from H_TOTAL-1 to 0.
  - On an H wrap, V increments and wraps from V_TOTAL-1 to 0.
  - On a V wrap, `frame_count` increments, wrapping modulo 2^16.
- In IDLE, H and V hold 0. `valid_video`, `frame_start`, `line_start` and the undelayed sync terms are 0.
- `valid_video` = (H < IMAGE_WIDTH) && (V < IMAGE_HEIGHT).
- Undelayed HS term = (H in [IMAGE_WIDTH+HFP_WIDTH, IMAGE_WIDTH+HFP_WIDTH+HSYNCH_WIDTH)), i.e. H = 1390..1429.
- Undelayed VS term = (V in [IMAGE_HEIGHT+VFP_HEIGHT, IMAGE_HEIGHT+VFP_HEIGHT+VSYNCH_HEIGHT)), i.e. V = 725..729.
- The delay line shifts every clock, in every state, so IDLE drains zeros through it.
- Position arithmetic is unsigned and zero-extended to 32 bits. Counters never exceed TOTAL-1.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - state = IDLE
  - `H_pos`, `V_pos`, `frame_count` = 0
  - every 1-bit output = 0, including all delay stages
- Outputs are registered. `valid_video`, `frame_start` and `line_start` are decoded from registered state/counters and are valid in the same cycle as the position.
- Start latency: `enable` sampled high in IDLE at edge N. In cycle N+1: state RUN, position (0,0), `frame_start`=1, `line_start`=1, `valid_video`=1.
- `VGA_HS`, `VGA_VS` and `valid_video_d` equal the undelayed terms from PIPE_DELAY cycles earlier. With PIPE_DELAY=0 they are equal to the undelayed terms.
- Deasserting `enable` never truncates a frame. The last frame output before IDLE is always complete.
- Reset asserted mid-frame forces IDLE immediately. After `reset_n` rises, `enable` starts at (0,0) as above.

## Structure
- Package `vga_pkg` holds:
  - the timing constants (the parameter defaults, H_TOTAL, V_TOTAL)
  - the state enum `vga_state_t` {IDLE, RUN, STOPPING}
- The pixel generator imports the same package.
- Sub-module `sync_delay`: parameterized-depth shift register, 3 bits wide, carrying {valid, hs, vs}. It has its own `clk`/`reset_n` and resets to 0.

## Test plan
- Reset: hold `reset_n`=0 with `enable`=1 → all outputs 0 and `H_pos`=`V_pos`=0. Release reset → `frame_start`=1 on the cycle after the first sampled `enable`.
- Line timing: run 1650 clocks.
  - `valid_video`=1 for H=0..1279.
  - `VGA_HS`=1 for exactly 40 clocks, starting at H=1390+PIPE_DELAY.
  - `line_start` pulses again at clock 1650.
- Frame wrap: run 2 full frames (2×1,237,500 clocks) → `frame_count`=2, `VGA_VS` high for 5 lines starting at V=725, `frame_start` spaced exactly 1,237,500 clocks apart.
- Graceful stop: drop `enable` at position (500,300) → counting continues to (1649,749), then `running`=0 and position (0,0). Delayed outputs reach 0 within PIPE_DELAY cycles.
- Resume during STOPPING: drop `enable` at V=100, re-raise at V=200 → no discontinuity in H/V, no extra `frame_start`, state RUN.
- Async reset mid-frame: pulse `reset_n` low between clock edges at (1000,400) → outputs go to 0 immediately without waiting for a clock edge, `frame_count`=0, state IDLE.
